// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller sequencing CPU reset/enable/start with step mode and watchdog
module cpu_run_ctrl #(
    parameter int RST_CYCLES  = 4,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run_req,
    input  logic             abort_req,
    input  logic             mode_step,
    input  logic             step_req,
    input  logic             halt_in,
    output logic             cpu_reset,
    output logic             cpu_enable,
    output logic             cpu_start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int               HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);
    localparam bit                WDOG_EN   = (WDOG_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              rst_q;
    logic              en_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;
    logic              halt_hit;
    logic              wdog_hit;

    // halt_in and the watchdog are only meaningful in a cycle the CPU actually advanced
    always_comb begin
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        halt_hit = en_q & halt_in;
        wdog_hit = WDOG_EN & en_q & (cnt_q == WDOG_LAST);
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            cnt_q     <= '0;
            rst_q     <= 1'b1;
            en_q      <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (abort_req) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            rst_q     <= 1'b1;
            en_q      <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (run_req) begin
                        state_q   <= S_HOLD;
                        hold_q    <= '0;
                        cnt_q     <= '0;
                        rst_q     <= 1'b1;
                        en_q      <= 1'b0;
                        start_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                // hold_q reaching RST_CYCLES means RST_CYCLES full reset cycles have been seen
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= S_RUN;
                        rst_q   <= 1'b0;
                        start_q <= 1'b1;
                        en_q    <= ~mode_step;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (en_q) begin
                        cnt_q <= cnt_d;
                    end
                    if (halt_hit || wdog_hit) begin
                        state_q   <= S_DONE;
                        rst_q     <= 1'b0;
                        en_q      <= 1'b0;
                        start_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= ~halt_hit;
                    end else begin
                        en_q <= mode_step ? step_req : 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    rst_q   <= 1'b1;
                    en_q    <= 1'b0;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_reset  = rst_q;
    assign cpu_enable = en_q;
    assign cpu_start  = start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign cycle_cnt  = cnt_q;

endmodule
